alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_pkg.sv | 32 +++
 rtl/alu_issue.sv | 125 ++++++++++++
 tb/tb_alu_issue.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue sequencer: widths, function codes,
// status bit positions and the FSM state encoding.
package alu_issue_pkg;

  localparam int REG_WIDTH = 8;
  localparam int OPP_WIDTH = 4;

  localparam logic [OPP_WIDTH-1:0] ALU_NOP = 4'h0;
  localparam logic [OPP_WIDTH-1:0] SUM     = 4'h1;
  localparam logic [OPP_WIDTH-1:0] AND     = 4'h2;
  localparam logic [OPP_WIDTH-1:0] OR      = 4'h3;
  localparam logic [OPP_WIDTH-1:0] XOR     = 4'h4;
  localparam logic [OPP_WIDTH-1:0] SR      = 4'h5;

  localparam int CARRY = 0;
  localparam int ZERO  = 1;
  localparam int OVF   = 6;
  localparam int NEG   = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic op_legal(input logic [OPP_WIDTH-1:0] f);
    return f inside {SUM, AND, OR, XOR, SR};
  endfunction

endpackage

// File: rtl/alu_issue.sv
// Issues one operation to an external ALU and captures its result/status.
// Optional WAIT timeout abort is compiled in with ALU_ISSUE_TIMEOUT_EN.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                 phi1,
  input  logic                 reset_n,
  input  logic                 req,
  input  logic [OPP_WIDTH-1:0] op_func,
  input  logic [REG_WIDTH-1:0] op_a,
  input  logic [REG_WIDTH-1:0] op_b,
  input  logic [REG_WIDTH-1:0] p_in,
  input  logic [REG_WIDTH-1:0] alu_dout,
  input  logic [REG_WIDTH-1:0] alu_status,
  input  logic                 alu_wout,
  output logic [REG_WIDTH-1:0] alu_a,
  output logic [REG_WIDTH-1:0] alu_b,
  output logic [REG_WIDTH-1:0] alu_status_in,
  output logic [OPP_WIDTH-1:0] alu_func,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [REG_WIDTH-1:0] result,
  output logic [REG_WIDTH-1:0] status
);

  state_t               state, state_nxt;
  logic [OPP_WIDTH-1:0] func_q;
  logic                 err_q;
  logic                 accept, reject, capture, abort;
  logic                 timeout_hit;

`ifdef ALU_ISSUE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] to_cnt;

  // Counter restarts while the operands are issued, so it counts WAIT cycles only.
  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (state == ST_ISSUE) begin
      to_cnt <= '0;
    end else if (state == ST_WAIT) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout_hit = (to_cnt == TO_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (op_legal(op_func)) begin
            accept    = 1'b1;
            state_nxt = ST_CLEAR;
          end else begin
            reject    = 1'b1;
            state_nxt = ST_DONE;
          end
        end
      end
      ST_CLEAR: state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (alu_wout) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end else if (timeout_hit) begin
          abort     = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operands are latched once at acceptance and stay stable through WAIT.
  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      func_q        <= ALU_NOP;
      err_q         <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_status_in <= '0;
      result        <= '0;
      status        <= '0;
    end else begin
      state <= state_nxt;
      err_q <= reject | abort;
      if (accept) begin
        func_q        <= op_func;
        alu_a         <= op_a;
        alu_b         <= op_b;
        alu_status_in <= p_in;
      end
      if (capture) begin
        result <= alu_dout;
        status <= alu_status;
      end
    end
  end

  // NOP outside ISSUE/WAIT gives the ALU a fresh edge even for repeated ops.
  assign alu_func = (state == ST_ISSUE || state == ST_WAIT) ? func_q : ALU_NOP;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign err      = (state == ST_DONE) && err_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: behavioural ALU stub, vector table,
// directed corner sequences and randomized ops against a reference model.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic                 phi1 = 1'b0;
  logic                 reset_n;
  logic                 req;
  logic [OPP_WIDTH-1:0] op_func;
  logic [REG_WIDTH-1:0] op_a, op_b, p_in;
  logic [REG_WIDTH-1:0] alu_dout, alu_status;
  logic                 alu_wout;
  logic [REG_WIDTH-1:0] alu_a, alu_b, alu_status_in;
  logic [OPP_WIDTH-1:0] alu_func;
  logic                 busy, done, err;
  logic [REG_WIDTH-1:0] result, status;

  alu_issue dut (
    .phi1(phi1), .reset_n(reset_n), .req(req), .op_func(op_func),
    .op_a(op_a), .op_b(op_b), .p_in(p_in),
    .alu_dout(alu_dout), .alu_status(alu_status), .alu_wout(alu_wout),
    .alu_a(alu_a), .alu_b(alu_b), .alu_status_in(alu_status_in),
    .alu_func(alu_func), .busy(busy), .done(done), .err(err),
    .result(result), .status(status)
  );

  always #5 phi1 = ~phi1;

  int n_tests = 0;
  int n_fail  = 0;
  bit alu_stuck = 1'b0;
  int alu_delay = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference ALU behaviour: returns {status, result}.
  function automatic logic [15:0] alu_ref(input logic [OPP_WIDTH-1:0] f,
                                          input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] sin);
    logic [8:0] w;
    logic [7:0] r;
    logic [7:0] s;
    s = sin;
    r = 8'h00;
    case (f)
      SUM: begin
        w = {1'b0, a} + {1'b0, b} + {8'h00, sin[CARRY]};
        r = w[7:0];
        s[CARRY] = w[8];
        s[OVF] = (a[7] == b[7]) && (r[7] != a[7]);
      end
      AND: r = a & b;
      OR:  r = a | b;
      XOR: r = a ^ b;
      SR: begin
        r = a >> 1;
        s[CARRY] = a[0];
      end
      default: r = 8'h00;
    endcase
    s[ZERO] = (r == 8'h00);
    s[NEG]  = r[7];
    return {s, r};
  endfunction

  // ALU stub: result valid after alu_delay low WAIT cycles, unless stuck.
  initial begin
    int cnt;
    cnt = 0;
    alu_wout = 1'b0;
    alu_dout = '0;
    alu_status = '0;
    forever begin
      @(negedge phi1);
      if (alu_func == ALU_NOP) begin
        cnt = 0;
        alu_wout = 1'b0;
      end else begin
        cnt++;
        alu_wout = !alu_stuck && (cnt >= alu_delay + 2);
      end
      {alu_status, alu_dout} = alu_ref(alu_func, alu_a, alu_b, alu_status_in);
    end
  end

  // One request; k counts cycles after the sampling edge (k=1 is the first).
  task automatic run_op(input logic [OPP_WIDTH-1:0] f, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] p, input int d,
                        input bit chk_drive, output int done_k, output logic e);
    @(negedge phi1);
    req = 1'b1; op_func = f; op_a = a; op_b = b; p_in = p; alu_delay = d;
    done_k = -1;
    e = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge phi1);
      if (k == 1) begin
        req = 1'b0;
        check("nop_first_cycle", alu_func, ALU_NOP);
      end
      if (k == 2 && chk_drive) begin
        check("issue_func", alu_func, f);
        check("issue_a", alu_a, a);
        check("issue_b", alu_b, b);
        check("issue_status_in", alu_status_in, p);
      end
      if (done) begin
        done_k = k;
        e = err;
        break;
      end
    end
    if (done_k < 0) check("done_timeout", 0, 1);
  endtask

  typedef struct {
    logic [OPP_WIDTH-1:0] f;
    logic [7:0] a, b, p;
    int d;
    logic [7:0] er;
    bit ec, en, ee;
    int ek;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int dk;
    logic de;
    logic [15:0] m;
    logic [7:0] mdl_res, mdl_st;
    int ndone;
    int dks[3];

    tbl[0] = '{SUM,   8'h7F, 8'h01, 8'h00, 0, 8'h80, 1'b0, 1'b1, 1'b0, 4};
    tbl[1] = '{SUM,   8'hFF, 8'h01, 8'h00, 0, 8'h00, 1'b1, 1'b0, 1'b0, 4};
    tbl[2] = '{SUM,   8'h01, 8'h01, 8'h01, 1, 8'h03, 1'b0, 1'b0, 1'b0, 5};
    tbl[3] = '{AND,   8'hF0, 8'h3C, 8'h00, 0, 8'h30, 1'b0, 1'b0, 1'b0, 4};
    tbl[4] = '{OR,    8'h0F, 8'hF0, 8'h01, 0, 8'hFF, 1'b1, 1'b1, 1'b0, 4};
    tbl[5] = '{XOR,   8'hAA, 8'hFF, 8'h00, 2, 8'h55, 1'b0, 1'b0, 1'b0, 6};
    tbl[6] = '{SR,    8'h81, 8'h00, 8'h00, 0, 8'h40, 1'b1, 1'b0, 1'b0, 4};
    tbl[7] = '{4'hF,  8'h12, 8'h34, 8'h00, 0, 8'h40, 1'b1, 1'b0, 1'b1, 1};
    tbl[8] = '{ALU_NOP, 8'h56, 8'h78, 8'h80, 0, 8'h40, 1'b1, 1'b0, 1'b1, 1};

    reset_n = 1'b0; req = 1'b0; op_func = ALU_NOP; op_a = '0; op_b = '0; p_in = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_result_status", {result, status}, 0);
    check("rst_alu_drive", {alu_a, alu_b, alu_status_in}, 0);
    check("rst_alu_func", alu_func, ALU_NOP);
    repeat (3) @(negedge phi1);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].d, !tbl[i].ee, dk, de);
      check($sformatf("vec%0d_latency", i), dk, tbl[i].ek);
      check($sformatf("vec%0d_err", i), de, tbl[i].ee);
      check($sformatf("vec%0d_result", i), result, tbl[i].er);
      check($sformatf("vec%0d_carry", i), status[CARRY], tbl[i].ec);
      check($sformatf("vec%0d_neg", i), status[NEG], tbl[i].en);
    end

    // Back-to-back identical ops, each must see its own NOP cycle.
    for (int i = 0; i < 2; i++) begin
      run_op(SUM, 8'h01, 8'h01, 8'h00, 0, 1'b1, dk, de);
      check($sformatf("b2b%0d_latency", i), dk, 4);
      check($sformatf("b2b%0d_result", i), result, 8'h02);
    end

    m = alu_ref(SUM, 8'h01, 8'h01, 8'h00);
    mdl_st = m[15:8];
    mdl_res = m[7:0];
    for (int i = 0; i < 40; i++) begin
      logic [OPP_WIDTH-1:0] f;
      logic [7:0] a, b, p;
      int d;
      bit legal;
      f = OPP_WIDTH'($urandom_range(0, 7));
      a = 8'($urandom); b = 8'($urandom); p = 8'($urandom);
      d = $urandom_range(0, 3);
      legal = (f >= SUM) && (f <= SR);
      run_op(f, a, b, p, d, legal, dk, de);
      if (legal) begin
        m = alu_ref(f, a, b, p);
        mdl_st = m[15:8];
        mdl_res = m[7:0];
      end
      check($sformatf("rnd%0d_latency", i), dk, legal ? 4 + d : 1);
      check($sformatf("rnd%0d_err", i), de, !legal);
      check($sformatf("rnd%0d_result", i), result, mdl_res);
      check($sformatf("rnd%0d_status", i), status, mdl_st);
    end

    // Reset during WAIT.
    alu_stuck = 1'b1;
    @(negedge phi1);
    req = 1'b1; op_func = SUM; op_a = 8'h11; op_b = 8'h22; p_in = 8'h00;
    @(negedge phi1);
    req = 1'b0;
    repeat (2) @(negedge phi1);
    check("pre_reset_wait_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_busy_done_err", {busy, done, err}, 0);
    check("midrst_result_status", {result, status}, 0);
    check("midrst_alu_drive", {alu_a, alu_b, alu_status_in}, 0);
    check("midrst_alu_func", alu_func, ALU_NOP);
    alu_stuck = 1'b0;
    @(negedge phi1);
    #1 reset_n = 1'b1;
    @(negedge phi1);
    check("post_rst_idle", {busy, done}, 0);
    run_op(AND, 8'hF0, 8'h3C, 8'h00, 0, 1'b1, dk, de);
    check("post_rst_latency", dk, 4);
    check("post_rst_result", result, 8'h30);

    // req held high: one op per five cycles.
    ndone = 0;
    dks[0] = -1; dks[1] = -1; dks[2] = -1;
    @(negedge phi1);
    req = 1'b1; op_func = SUM; op_a = 8'h01; op_b = 8'h01; p_in = 8'h00; alu_delay = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge phi1);
      if (k == 15) req = 1'b0;
      if (done) begin
        if (ndone < 3) dks[ndone] = k;
        ndone++;
      end
    end
    check("held_req_count", ndone, 3);
    check("held_req_done0", dks[0], 4);
    check("held_req_done1", dks[1], 9);
    check("held_req_done2", dks[2], 14);

    // WAIT with no result-valid.
    alu_stuck = 1'b1;
`ifdef ALU_ISSUE_TIMEOUT_EN
    run_op(SUM, 8'h05, 8'h06, 8'h00, 0, 1'b1, dk, de);
    check("timeout_latency", dk, 11);
    check("timeout_err", de, 1);
    check("timeout_result_kept", result, 8'h02);
`else
    begin
      int busy_low;
      int saw_done;
      busy_low = 0;
      saw_done = 0;
      @(negedge phi1);
      req = 1'b1; op_func = SUM; op_a = 8'h05; op_b = 8'h06; p_in = 8'h00;
      @(negedge phi1);
      req = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(negedge phi1);
        if (!busy) busy_low++;
        if (done) saw_done++;
      end
      check("stuck_busy_low_cycles", busy_low, 0);
      check("stuck_no_done", saw_done, 0);
      alu_stuck = 1'b0;
      dk = -1;
      for (int k = 1; k <= 10; k++) begin
        @(negedge phi1);
        if (done) begin
          dk = k;
          de = err;
          break;
        end
      end
      check("stuck_release_done", dk, 2);
      check("stuck_release_err", de, 0);
      check("stuck_release_result", result, 8'h0B);
    end
`endif
    alu_stuck = 1'b0;
    repeat (3) @(negedge phi1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
